// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the parametrised sequence detector.
// Build option: SEQDET_COUNT_EN (in seq_detect_param) adds the match counter.
package seqdet_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // Counter width that holds 0..data_w matches.
    function automatic int cnt_w_of(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/seq_serializer.sv
// Load capture and MSB-first serialiser. ser_bit is the bit that the next
// shift moves out; last_bit flags the shift that moves out the final bit.
module seq_serializer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic              ser_bit,
    output logic              last_bit
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);

    logic [DATA_W-1:0] sreg;
    logic [BW-1:0]     bcnt;

    // Capture the word on start, then shift left once per enabled cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            sreg <= '0;
            bcnt <= '0;
        end else if (start) begin
            sreg <= din;
            bcnt <= '0;
        end else if (shift_en) begin
            sreg <= {sreg[DATA_W-2:0], 1'b0};
            bcnt <= bcnt + BW'(1);
        end
    end

    assign ser_bit  = sreg[DATA_W-1];
    assign last_bit = shift_en && (bcnt == LAST_IDX);

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: shifts a loaded word out MSB-first
// and flags every window that equals the loaded pattern.
// Build option: define SEQDET_COUNT_EN to add the match_cnt port and counter.
//
// Handshake: load is the request and !busy is the ready; a word is taken on
// any rising edge with load=1 and busy=0 (IDLE or DONE). A load while busy
// is dropped without effect. clr overrides a simultaneous load.
module seq_detect_param
    import seqdet_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PAT_W  = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        load,
    input  logic [DATA_W-1:0]           din,
    input  logic [PAT_W-1:0]            pattern,
    input  logic                        overlap,
    output logic                        busy,
    output logic                        bit_out,
    output logic                        hit,
    output logic                        found,
    output logic                        done,
`ifdef SEQDET_COUNT_EN
    output logic [cnt_w_of(DATA_W)-1:0] match_cnt,
`endif
    output state_t                      state_dbg
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  window_q, pat_q, win_shift;
    logic [FW-1:0]     fill_q, fill_inc;
    logic              ovl_q, bit_q, hit_q, found_q, done_q;
    logic              accept, match, ser_bit, last_bit, shifting;

    assign accept   = load && (state_q != SHIFT);
    assign shifting = (state_q == SHIFT);

    seq_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk      (clk),
        .clr      (clr),
        .start    (accept),
        .shift_en (shifting),
        .din      (din),
        .ser_bit  (ser_bit),
        .last_bit (last_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = load ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window after this shift, saturating fill, and the match decision.
    always_comb begin
        win_shift = {window_q[PAT_W-2:0], ser_bit};
        fill_inc  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
        match     = shifting && (fill_inc == FILL_FULL) && (win_shift == pat_q);
    end

    // Window, fill, held pattern/mode and the registered result flags.
    always_ff @(posedge clk) begin
        if (clr) begin
            window_q <= '0;
            fill_q   <= '0;
            pat_q    <= '0;
            ovl_q    <= 1'b0;
            bit_q    <= 1'b0;
            hit_q    <= 1'b0;
            found_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            hit_q  <= 1'b0;
            done_q <= 1'b0;
            if (accept) begin
                window_q <= '0;
                fill_q   <= '0;
                found_q  <= 1'b0;
                pat_q    <= pattern;
                ovl_q    <= overlap;
            end else if (shifting) begin
                window_q <= win_shift;
                bit_q    <= ser_bit;
                done_q   <= last_bit;
                if (match) begin
                    hit_q   <= 1'b1;
                    found_q <= 1'b1;
                    // Non-overlapping mode needs PAT_W fresh bits per match.
                    fill_q  <= ovl_q ? FILL_FULL : '0;
                end else begin
                    fill_q  <= fill_inc;
                end
            end
        end
    end

`ifdef SEQDET_COUNT_EN
    localparam int CNT_W = cnt_w_of(DATA_W);
    logic [CNT_W-1:0] cnt_q;

    // Matches in the current word; cannot exceed DATA_W-PAT_W+1.
    always_ff @(posedge clk) begin
        if (clr)         cnt_q <= '0;
        else if (accept) cnt_q <= '0;
        else if (match)  cnt_q <= cnt_q + CNT_W'(1);
    end

    assign match_cnt = cnt_q;
`endif

    assign busy      = shifting;
    assign bit_out   = bit_q;
    assign hit       = hit_q;
    assign found     = found_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed table-driven bench for seq_detect_param (DATA_W=8, PAT_W=4).
module tb_seq_detect_param;
  import seqdet_pkg::*;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = cnt_w_of(DATA_W);

  logic              clk = 1'b0;
  logic              clr, load, overlap;
  logic [DATA_W-1:0] din;
  logic [PAT_W-1:0]  pattern;
  logic              busy, bit_out, hit, found, done;
  logic [CNT_W-1:0]  match_cnt;
  state_t            state_dbg;

  int n_vec = 0;
  int n_bad = 0;

  seq_detect_param #(.DATA_W(DATA_W), .PAT_W(PAT_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .load      (load),
    .din       (din),
    .pattern   (pattern),
    .overlap   (overlap),
    .busy      (busy),
    .bit_out   (bit_out),
    .hit       (hit),
    .found     (found),
    .done      (done),
`ifdef SEQDET_COUNT_EN
    .match_cnt (match_cnt),
`endif
    .state_dbg (state_dbg)
  );

`ifndef SEQDET_COUNT_EN
  assign match_cnt = '0;
`endif

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] din;
    logic [PAT_W-1:0]  pat;
    logic              ovl;
    logic [DATA_W-1:0] hits;   // bit k-1 set: hit in the cycle after edge Ek
    logic [CNT_W-1:0]  cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load one word, optionally pulse an ignored load before edge ign_k,
  // and check everything up to the DONE cycle.
  task automatic run_word(input vec_t v, input int ign_k, input string tag);
    logic [DATA_W-1:0] h, b, dn, bits;
    @(negedge clk);
    din = v.din; pattern = v.pat; overlap = v.ovl; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check({tag, ".busy_e0"}, busy, 1);
    for (int k = 1; k <= DATA_W; k++) begin
      if (k == ign_k) begin
        din = ~v.din; pattern = ~v.pat; overlap = ~v.ovl; load = 1'b1;
      end
      @(posedge clk); #1;
      load = 1'b0; din = v.din; pattern = v.pat; overlap = v.ovl;
      h[k-1]         = hit;
      b[k-1]         = busy;
      dn[k-1]        = done;
      bits[DATA_W-k] = bit_out;
    end
    check({tag, ".hits"}, h, v.hits);
    check({tag, ".busy"}, b, 8'h7F);
    check({tag, ".done"}, dn, 8'h80);
    check({tag, ".bits"}, bits, v.din);
    check({tag, ".found"}, found, (v.hits != 0));
    check({tag, ".state_done"}, state_dbg, DONE);
`ifdef SEQDET_COUNT_EN
    check({tag, ".cnt"}, match_cnt, v.cnt);
`endif
  endtask

  // One edge with no load after DONE: back to IDLE, results hold.
  task automatic idle_step(input vec_t v, input string tag);
    @(posedge clk); #1;
    check({tag, ".idle_state"}, state_dbg, IDLE);
    check({tag, ".idle_done"}, done, 0);
    check({tag, ".idle_found"}, found, (v.hits != 0));
    check({tag, ".idle_bit"}, bit_out, v.din[0]);
  endtask

  initial begin
    vec_t v;
    logic stray;
    vecs[0] = '{8'b1101_1011, 4'b1011, 1'b1, 8'h90, 4'd2};
    vecs[1] = '{8'b1101_1011, 4'b1011, 1'b0, 8'h10, 4'd1};
    vecs[2] = '{8'hFF,        4'hF,    1'b1, 8'hF8, 4'd5};
    vecs[3] = '{8'hFF,        4'hF,    1'b0, 8'h88, 4'd2};
    vecs[4] = '{8'h00,        4'b1011, 1'b1, 8'h00, 4'd0};
    vecs[5] = '{8'b1010_1010, 4'b1010, 1'b1, 8'hA8, 4'd3};
    vecs[6] = '{8'b1010_1010, 4'b1010, 1'b0, 8'h88, 4'd2};
    vecs[7] = '{8'hB0,        4'b1011, 1'b0, 8'h08, 4'd1};
    vecs[8] = '{8'h0B,        4'b1011, 1'b1, 8'h80, 4'd1};

    // reset
    clr = 1'b1; load = 1'b0; din = '0; pattern = '0; overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.bit_out", bit_out, 0);
    check("rst.hit", hit, 0);
    check("rst.found", found, 0);
    check("rst.done", done, 0);
    check("rst.state", state_dbg, IDLE);
    check("rst.cnt", match_cnt, 0);
    clr = 1'b0;

    // table vectors
    for (int i = 0; i < 9; i++) begin
      run_word(vecs[i], 0, $sformatf("vec%0d", i));
      idle_step(vecs[i], $sformatf("vec%0d", i));
    end

    // load during shift at E3 is ignored
    run_word(vecs[0], 3, "ign");
    idle_step(vecs[0], "ign");

    // back-to-back: reload in the DONE cycle clears found for the new word
    run_word(vecs[2], 0, "b2b_a");
    run_word(vecs[4], 0, "b2b_b");
    idle_step(vecs[4], "b2b_b");

    // clr together with load at E4, mid-shift
    @(negedge clk);
    din = 8'hFF; pattern = 4'hF; overlap = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("clr.pre_bit", bit_out, 1);
    clr = 1'b1; load = 1'b1; din = 8'h0F;
    @(posedge clk); #1;
    clr = 1'b0; load = 1'b0;
    check("clr.busy", busy, 0);
    check("clr.hit", hit, 0);
    check("clr.found", found, 0);
    check("clr.done", done, 0);
    check("clr.bit_out", bit_out, 0);
    check("clr.state", state_dbg, IDLE);
    check("clr.cnt", match_cnt, 0);
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      stray = stray | done | busy | hit;
    end
    check("clr.quiet", stray, 0);
    run_word(vecs[5], 0, "post_clr");
    idle_step(vecs[5], "post_clr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised successor to the fixed 8-bit parallel-to-serial sequence detector. It accepts a DATA_W-bit word through a load handshake and shifts it out MSB-first. Every bit is checked against a PAT_W-bit pattern loaded at run time, in either overlapping or non-overlapping mode. Outputs are a per-match pulse, a sticky found flag, a done pulse and an optional match counter. It sits between the switch/parallel input logic and the LED/display outputs of the lab top level.

## Interface
- DATA_W, 8, width of parallel input word (2..32)
- PAT_W, 4, pattern length; 2 <= PAT_W <= DATA_W
- CNT_W, $clog2(DATA_W+1), match counter width (derived, not overridden)

- clk  in  1  single clock, rising edge
- clr  in  1  synchronous, active-high reset
- load  in  1  start request; accepted on an edge where busy==0
- din  in  DATA_W  word to scan; sampled on accepted load
- pattern  in  PAT_W  pattern; sampled on accepted load
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping; sampled on accepted load
- busy  out  1  high while shifting
- bit_out  out  1  bit most recently shifted into the window
- hit  out  1  one-cycle pulse per match
- found  out  1  sticky: any match since last accepted load
- done  out  1  one-cycle pulse after the last bit
- match_cnt  out  CNT_W  matches in current/last word (SEQDET_COUNT_EN only)

## Operation
- FSM states: IDLE, SHIFT, DONE (registered Moore machine; all outputs decode from registers).
- IDLE or DONE with load=1 -> SHIFT:
  - capture din into shift register, pattern and overlap into holding registers;
  - clear window, fill count, found and match_cnt.
- SHIFT, each edge:
  - shift the shift-register MSB into window LSB (window shifts left);
  - fill = min(fill+1, PAT_W);
  - bit_out = shifted bit.
- Match condition: fill reaches PAT_W on this edge and the new window equals the held pattern.
  - On a match, the same edge sets hit and found and increments match_cnt.
  - overlap=0: a match resets fill to 0, so the next match needs PAT_W fresh bits.
  - overlap=1: fill stays at PAT_W.
- After DATA_W shifts: -> DONE. done pulses for one cycle; found, match_cnt and bit_out hold.
- DONE without load -> IDLE on the next edge. IDLE holds all results.
- load while busy: ignored, no effect.
- clr, any state: -> IDLE. Window, fill, shift register, bit_out, hit, found, done and match_cnt go to 0. clr overrides a simultaneous load.
- Reset values: busy=0, bit_out=0, hit=0, found=0, done=0, match_cnt=0.

## Timing
- Load accepted at edge E0. Bits DATA_W-1..0 enter the window at edges E1..E_DATA_W.
- busy is high from after E0 through the cycle ending at E_DATA_W.
- A bit completing a match at edge Ek gives hit=1 for exactly the cycle after Ek (latency 1 from the bit's edge).
- done=1 for the cycle after E_DATA_W, coincident with busy=0.
- First accepted reload: at E_DATA_W+1 (in DONE). Back-to-back throughput is one word per DATA_W+1 cycles.
- match_cnt never overflows: the maximum is DATA_W-PAT_W+1 < 2^CNT_W.

## Configuration
- SEQDET_COUNT_EN defined: the match_cnt port and its counter register exist.
- SEQDET_COUNT_EN undefined: match_cnt port and logic are removed. All other behaviour is identical.

## Structure
- Package seqdet_pkg holds:
  - state enum type (IDLE/SHIFT/DONE);
  - localparam encodings;
  - a function for the CNT_W derivation.
- One sub-module, seq_serializer: load capture, MSB-first shift register, bit counter, last-bit strobe. Window compare, FSM and outputs stay in seq_detect_param.

## Test plan
- DATA_W=8, PAT_W=4, din=8'b11011011, pattern=4'b1011, overlap=1 -> hit in cycles after E5 and E8, match_cnt=2, found=1, done after E8.
- Same word and pattern, overlap=0 -> single hit after E5, match_cnt=1 (fill reset leaves only 3 bits).
- din=8'hFF, pattern=4'hF -> overlap=1: 5 hits (E4..E8), match_cnt=5; overlap=0: hits after E4 and E8, match_cnt=2.
- din=8'h00, pattern=4'b1011 -> no hit, found=0, done pulses once after E8, busy low 9 cycles after load.
- Pulse load again at E3 during shift, with different din -> ignored; results match the first word only.
- Assert clr at E4 mid-shift, together with load -> all outputs 0 next cycle, state IDLE, no done pulse; a new load afterwards scans normally.
